// File: rtl/ram_port_arbiter.sv
// Two-client round-robin arbiter/sequencer for the 32x4 RAM single port.
// Ports: clk, rst_n (sync, active-low); cN_req/we/addr/wdata in; cN_gnt,
// cN_rvalid, cN_rdata out; ram_we/a/di out, ram_spo in; busy out.
// Macro RAM_CLEAR_EN: adds an INIT state that writes INIT_VAL to every
// location after reset before any client is granted.
module ram_port_arbiter #(
  parameter int AW = 5,
  parameter int DW = 4,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c0_req,
  input  logic          c0_we,
  input  logic [AW-1:0] c0_addr,
  input  logic [DW-1:0] c0_wdata,
  output logic          c0_gnt,
  output logic          c0_rvalid,
  output logic [DW-1:0] c0_rdata,
  input  logic          c1_req,
  input  logic          c1_we,
  input  logic [AW-1:0] c1_addr,
  input  logic [DW-1:0] c1_wdata,
  output logic          c1_gnt,
  output logic          c1_rvalid,
  output logic [DW-1:0] c1_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_spo,
  output logic          busy
);

  logic          in_init;
  logic [AW-1:0] clr_a;
  logic          last;
  logic [AW-1:0] a_q;
  logic          rv0;
  logic          rv1;

`ifdef RAM_CLEAR_EN
  typedef enum logic {INIT, RUN} state_t;

  // One wider than the address so the terminal compare never wraps.
  localparam logic [AW:0] CLR_LAST = (AW+1)'((1 << AW) - 1);

  state_t      state;
  state_t      state_nx;
  logic [AW:0] clr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == INIT && clr_cnt == CLR_LAST)
      state_nx = RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)             clr_cnt <= '0;
    else if (state == INIT) clr_cnt <= clr_cnt + 1'b1;
  end

  assign in_init = (state == INIT);
  assign clr_a   = clr_cnt[AW-1:0];
`else
  assign in_init = 1'b0;
  assign clr_a   = '0;
`endif

  // Both requesting: favour the client that was not served last.
  assign c0_gnt = !in_init && c0_req && (!c1_req || last);
  assign c1_gnt = !in_init && c1_req && (!c0_req || !last);

  // Idle cycles keep the previous address and never write.
  always_comb begin
    ram_we = 1'b0;
    ram_a  = a_q;
    ram_di = '0;
    unique case (1'b1)
      in_init: begin
        ram_we = 1'b1;
        ram_a  = clr_a;
        ram_di = INIT_VAL;
      end
      c0_gnt: begin
        ram_we = c0_we;
        ram_a  = c0_addr;
        ram_di = c0_wdata;
      end
      c1_gnt: begin
        ram_we = c1_we;
        ram_a  = c1_addr;
        ram_di = c1_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b1;
      a_q  <= '0;
      rv0  <= 1'b0;
      rv1  <= 1'b0;
    end else begin
      a_q <= ram_a;
      rv0 <= c0_gnt && !c0_we;
      rv1 <= c1_gnt && !c1_we;
      if (c0_gnt)      last <= 1'b0;
      else if (c1_gnt) last <= 1'b1;
    end
  end

  assign c0_rvalid = rv0;
  assign c1_rvalid = rv1;
  assign c0_rdata  = rv0 ? ram_spo : '0;
  assign c1_rdata  = rv1 ? ram_spo : '0;
  assign busy      = in_init;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, directed table, random traffic.
// Expected values come from a rule-level reference model.
module tb_ram_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 4;
  localparam logic [3:0] INIT_VAL = 4'h0;
`ifdef RAM_CLEAR_EN
  localparam int CLR = 32;
`else
  localparam int CLR = 0;
`endif

  logic clk, rst_n;
  logic c0_req, c0_we, c1_req, c1_we;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic ram_we, busy;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_di, ram_spo;

  ram_port_arbiter #(.AW(AW), .DW(DW), .INIT_VAL(INIT_VAL)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr),
    .c0_wdata(c0_wdata), .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid),
    .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr),
    .c1_wdata(c1_wdata), .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid),
    .c1_rdata(c1_rdata),
    .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
    .ram_spo(ram_spo), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with registered read address.
  logic [DW-1:0] mem [32];
  logic [AW-1:0] a_reg;
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_di;
    a_reg <= ram_a;
  end
  assign ram_spo = mem[a_reg];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model state.
  int       m_last;
  bit       m_rv [2];
  logic [3:0] m_rd [2];
  logic [3:0] m_mem [32];
  int       m_aprev;
  int       m_remain;

  task automatic m_reset();
    m_last   = 1;
    m_rv[0]  = 0;
    m_rv[1]  = 0;
    m_aprev  = 0;
    m_remain = CLR;
  endtask

  logic s_g0, s_g1, s_rv0, s_rv1, s_busy;
  logic [3:0] s_rd0, s_rd1;

  task automatic step(input bit rst,
                      input bit r0, input bit w0, input logic [4:0] a0,
                      input logic [3:0] d0,
                      input bit r1, input bit w1, input logic [4:0] a1,
                      input logic [3:0] d1);
    int g;
    logic ewe;
    logic [4:0] ea;
    logic [3:0] edi;
    rst_n = rst;
    c0_req = r0; c0_we = w0; c0_addr = a0; c0_wdata = d0;
    c1_req = r1; c1_we = w1; c1_addr = a1; c1_wdata = d1;
    @(negedge clk);
    g = -1;
    ewe = 0;
    ea = 5'(m_aprev);
    edi = 4'h0;
    if (m_remain > 0) begin
      ewe = 1; ea = 5'(CLR - m_remain); edi = INIT_VAL;
    end else begin
      if (r0 && r1) g = 1 - m_last;
      else if (r0)  g = 0;
      else if (r1)  g = 1;
      if (g == 0) begin ewe = w0; ea = a0; edi = d0; end
      if (g == 1) begin ewe = w1; ea = a1; edi = d1; end
    end
    chk("gnt0", c0_gnt, g == 0);
    chk("gnt1", c1_gnt, g == 1);
    chk("busy", busy, m_remain > 0);
    chk("ram_we", ram_we, ewe);
    chk("ram_a", ram_a, ea);
    if (ewe) chk("ram_di", ram_di, edi);
    chk("rvalid0", c0_rvalid, m_rv[0]);
    chk("rvalid1", c1_rvalid, m_rv[1]);
    chk("rdata0", c0_rdata, m_rv[0] ? m_rd[0] : 4'h0);
    chk("rdata1", c1_rdata, m_rv[1] ? m_rd[1] : 4'h0);
    s_g0 = c0_gnt; s_g1 = c1_gnt; s_busy = busy;
    s_rv0 = c0_rvalid; s_rv1 = c1_rvalid;
    s_rd0 = c0_rdata; s_rd1 = c1_rdata;
    // Effects of the coming edge: the RAM ignores reset.
    if (g >= 0 && !ewe) m_rd[g] = m_mem[ea];
    if (ewe) m_mem[ea] = edi;
    if (!rst) m_reset();
    else begin
      if (m_remain > 0) m_remain--;
      m_rv[0] = (g == 0) && !w0;
      m_rv[1] = (g == 1) && !w1;
      if (g >= 0) m_last = g;
      m_aprev = ea;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit r0; bit w0; logic [4:0] a0; logic [3:0] d0;
    bit r1; bit w1; logic [4:0] a1; logic [3:0] d1;
    bit eg0; bit eg1; bit erv0; bit erv1;
    logic [3:0] erd0; logic [3:0] erd1;
  } vec_t;

  vec_t tv [18];

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tv[0]  = '{1,1,5,4'hA, 0,0,0,0, 1,0,0,0, 0,0};
    tv[1]  = '{1,0,5,0,    0,0,0,0, 1,0,0,0, 0,0};
    tv[2]  = '{0,0,0,0,    0,0,0,0, 0,0,1,0, 4'hA,0};
    tv[3]  = '{0,0,0,0,    0,0,0,0, 0,0,0,0, 0,0};
    tv[4]  = '{1,1,3,4'h3, 0,0,0,0, 1,0,0,0, 0,0};
    tv[5]  = '{0,0,0,0,    1,1,9,4'h9, 0,1,0,0, 0,0};
    tv[6]  = '{1,0,3,0,    1,0,9,0, 1,0,0,0, 0,0};
    tv[7]  = '{1,0,3,0,    1,0,9,0, 0,1,1,0, 4'h3,0};
    tv[8]  = '{1,0,3,0,    1,0,9,0, 1,0,0,1, 0,4'h9};
    tv[9]  = '{1,0,3,0,    1,0,9,0, 0,1,1,0, 4'h3,0};
    tv[10] = '{1,0,3,0,    1,0,9,0, 1,0,0,1, 0,4'h9};
    tv[11] = '{1,0,3,0,    1,0,9,0, 0,1,1,0, 4'h3,0};
    tv[12] = '{0,0,0,0,    0,0,0,0, 0,0,0,1, 0,4'h9};
    tv[13] = '{1,0,0,0,    0,0,0,0, 1,0,0,0, 0,0};
    tv[14] = '{1,1,2,4'h1, 1,1,2,4'h2, 0,1,1,0, 0,0};
    tv[15] = '{1,1,2,4'h1, 1,1,2,4'h2, 1,0,0,0, 0,0};
    tv[16] = '{1,0,2,0,    0,0,0,0, 1,0,0,0, 0,0};
    tv[17] = '{0,0,0,0,    0,0,0,0, 0,0,1,0, 4'h1,0};

    for (int i = 0; i < 32; i++) begin
      mem[i]   = (CLR > 0) ? 4'hF : 4'h0;
      m_mem[i] = mem[i];
    end
    rst_n = 0;
    c0_req = 0; c0_we = 0; c0_addr = 0; c0_wdata = 0;
    c1_req = 0; c1_we = 0; c1_addr = 0; c1_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Clear with c0 holding a read of 17.
    n = 0;
    while (n < 40) begin
      step(1, 1, 0, 17, 0, 0, 0, 0, 0);
      if (s_g0) break;
      n++;
    end
    chk("first_grant_cycle", n, CLR);
    idle();
    chk("rd17_valid", s_rv0, 1);
    chk("rd17_data", s_rd0, INIT_VAL);

    // Directed table.
    foreach (tv[i]) begin
      step(1, tv[i].r0, tv[i].w0, tv[i].a0, tv[i].d0,
           tv[i].r1, tv[i].w1, tv[i].a1, tv[i].d1);
      chk($sformatf("tv%0d_g0", i), s_g0, tv[i].eg0);
      chk($sformatf("tv%0d_g1", i), s_g1, tv[i].eg1);
      chk($sformatf("tv%0d_rv0", i), s_rv0, tv[i].erv0);
      chk($sformatf("tv%0d_rv1", i), s_rv1, tv[i].erv1);
      chk($sformatf("tv%0d_rd0", i), s_rd0, tv[i].erd0);
      chk($sformatf("tv%0d_rd1", i), s_rd1, tv[i].erd1);
    end

    // Reset in the middle of the clear sequence.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && i < CLR; i++) idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (n < 40) begin
      idle();
      if (!s_busy) break;
      n++;
    end
    chk("clear_len_after_rst", n, CLR);

    // Reset while a c1 read is pending.
    step(1, 0, 0, 0, 0, 1, 0, 9, 0);
    chk("mid_rd_gnt1", s_g1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (n < 40) begin
      step(1, 0, 0, 0, 0, 1, 0, 9, 0);
      if (n == 0) chk("rv1_dropped", s_rv1, 0);
      if (s_g1) break;
      n++;
    end
    chk("grant_after_rst", n, CLR);
    idle();

    // Random traffic, occasional reset.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 149) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1),
           5'($urandom_range(0, 7)), 4'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1),
           5'($urandom_range(0, 7)), 4'($urandom));
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-client round-robin arbiter and sequencer for the 32x4 dual-port RAM with registered read address.
- Shares the RAM's single write/read port (we, a, di, spo) between client 0 and client 1 using a req/gnt handshake.
- Returns read data with a fixed 1-cycle latency.
- Optionally clears the RAM after reset before granting any client. The RAM's second read port (dpra/dpo) is not driven by this block.

Parameters:
- AW, 5, RAM address width (depth 2**AW).
- DW, 4, RAM data width.
- INIT_VAL, 0, DW-bit value written to every location by the clear sequence.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- c0_req  input  1  client 0 access request. Held with c0_we/c0_addr/c0_wdata until c0_gnt.
- c0_we  input  1  client 0: 1=write, 0=read.
- c0_addr  input  AW  client 0 address.
- c0_wdata  input  DW  client 0 write data.
- c0_gnt  output  1  client 0 grant (combinational). The transfer occurs at the edge where c0_req&c0_gnt.
- c0_rvalid  output  1  client 0 read data valid (registered).
- c0_rdata  output  DW  client 0 read data.
- c1_req, c1_we, c1_addr, c1_wdata, c1_gnt, c1_rvalid, c1_rdata: same as client 0, for client 1.
- ram_we  output  1  to RAM we.
- ram_a  output  AW  to RAM a.
- ram_di  output  DW  to RAM di.
- ram_spo  input  DW  from RAM spo; reflects the address registered at the previous edge.
- busy  output  1  high while the clear sequence runs.

Behaviour:
- FSM states: INIT, RUN.
  - Reset entry: INIT with RAM_CLEAR_EN, RUN without it.
  - INIT→RUN on the edge where clr_cnt==2**AW-1.
- Reset (rst_n low at an edge):
  - state, clr_cnt=0, last=1 (client 1 treated as last granted).
  - c0_rvalid=c1_rvalid=0.
  - busy=1 in INIT, 0 in RUN.
  - Reset asserted mid-clear restarts the clear from address 0.
  - Reset asserted mid-read drops the pending rvalid.
- INIT:
  - Drives ram_we=1, ram_a=clr_cnt, ram_di=INIT_VAL.
  - clr_cnt increments each cycle; busy=1; c0_gnt=c1_gnt=0 regardless of req.
  - Takes exactly 2**AW cycles (32 at default).
- RUN arbitration (combinational):
  - Only one req high → that client is granted.
  - Both high → the client other than `last` is granted.
  - Neither high → no grant, ram_we=0, ram_a holds the previously driven value (no spurious write).
  - Never both gnts high.
- RUN datapath:
  - ram_we = granted client's we.
  - ram_a = granted client's addr.
  - ram_di = granted client's wdata.
- On a granted edge:
  - `last` is updated to the granted client.
  - If the access was a read, cN_rvalid=1 for exactly the next cycle; otherwise 0.
- cN_rdata = ram_spo while cN_rvalid=1; 0 otherwise.
- Read latency: 1 cycle from the grant edge. Back-to-back reads from one client give one rvalid per cycle.
- Read-after-write to the same address on consecutive grants returns the new data (RAM writes at the grant edge; read address registers at the next grant edge).
- Read and write to the same address cannot coincide (single port).
- Sustained conflict: grants strictly alternate 0,1,0,1. Neither client waits more than 1 cycle.
- A request withdrawn before grant is allowed and has no effect.
- Widths: clr_cnt is AW+1 bits so the terminal compare does not wrap. Addresses are not range-checked (AW bits cover the full depth).

Optional Feature:
- RAM_CLEAR_EN defined:
  - INIT state and clear sequence present; busy as above.
  - First grant is possible no earlier than cycle 2**AW after reset release.
- RAM_CLEAR_EN undefined:
  - No INIT state, no clr_cnt; busy tied 0.
  - Grants are possible in the first cycle after reset release.
  - RAM contents after reset are undefined.

Test Plan:
1. Clear (RAM_CLEAR_EN, INIT_VAL=0), reset release, c0_req=1 held:
   - busy=1 for 32 cycles; ram_we=1 with ram_a stepping 0..31; c0_gnt=0 throughout.
   - Grant occurs in cycle 32.
   - A subsequent read of address 17 returns 0.
2. Client 0 writes 0xA to address 5, then reads address 5:
   - c0_rvalid pulses for 1 cycle, one cycle after the read grant.
   - c0_rdata=0xA; c1_rvalid stays 0.
3. Both clients request continuously for 6 cycles (c0 reads addr 3, c1 reads addr 9, preloaded 0x3/0x9):
   - Grants go 0,1,0,1,0,1.
   - rvalids alternate with rdata 0x3/0x9.
4. Simultaneous write conflict (c0 writes 0x1 to addr 2, c1 writes 0x2 to addr 2, both held) after a c0 grant:
   - c1 is granted first, then c0.
   - A final read of addr 2 returns 0x1.
5. Reset mid-clear: rst_n low at clear cycle 10 for 1 cycle:
   - clr_cnt returns to 0, busy stays 1.
   - Clear runs a full 32 cycles afterwards.
6. Reset mid-read: c1 read granted, rst_n low at the next edge:
   - c1_rvalid=0 after that edge.
   - No grant until busy drops (or immediately with RAM_CLEAR_EN undefined).
